// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : spi_sclk_gen
//  Purpose  : SPI serial-clock burst generator. On start it latches the
//             half-period divider, burst length and idle polarity, then emits
//             N SCLK cycles with one-cycle lead/trail edge strobes and a done
//             pulse on normal completion. All outputs are registered.
//  Revision : 1.0  initial release
// ============================================================================
module spi_sclk_gen #(
   parameter int DIV_W = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [DIV_W-1:0] div_half,
   input  logic [CNT_W-1:0] n_cycles,
   input  logic             cpol,
   output logic             sclk,
   output logic             lead_stb,
   output logic             trail_stb,
   output logic             busy,
   output logic             done
);

   localparam logic [DIV_W-1:0] c_HCNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W:0]   c_TCNT_ONE = {{CNT_W{1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // Latched burst configuration
   logic [DIV_W-1:0] r_d;
   logic [CNT_W-1:0] r_n;
   logic             r_cpol;

   // Half-period counter and toggle counter (one bit wider than N so 2N fits)
   logic [DIV_W-1:0] r_hcnt;
   logic [CNT_W:0]   r_tcnt;

   // Registered outputs
   logic r_sclk;
   logic r_lead;
   logic r_trail;
   logic r_busy;
   logic r_done;

   // Next-state values
   logic [DIV_W-1:0] w_d_nxt;
   logic [CNT_W-1:0] w_n_nxt;
   logic             w_cpol_nxt;
   logic [DIV_W-1:0] w_hcnt_nxt;
   logic [CNT_W:0]   w_tcnt_nxt;
   logic             w_sclk_nxt;
   logic             w_lead_nxt;
   logic             w_trail_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;

   logic w_start_ok;
   logic w_tgl;
   logic w_last_tgl;

   assign w_start_ok = start & ~abort & (n_cycles != '0);
   assign w_tgl      = (r_hcnt == r_d);
   // The toggle about to happen is number 2N when 2N-1 toggles are behind us
   assign w_last_tgl = (r_tcnt == ({r_n, 1'b0} - c_TCNT_ONE));

   // FSM state register
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and next-output decode; abort outranks every RUN event
   always_comb begin
      w_state_nxt = r_state;
      w_d_nxt     = r_d;
      w_n_nxt     = r_n;
      w_cpol_nxt  = r_cpol;
      w_hcnt_nxt  = r_hcnt;
      w_tcnt_nxt  = r_tcnt;
      w_sclk_nxt  = r_sclk;
      w_lead_nxt  = 1'b0;
      w_trail_nxt = 1'b0;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_sclk_nxt = cpol;
            w_busy_nxt = 1'b0;
            if (w_start_ok) begin
               w_state_nxt = S_RUN;
               w_d_nxt     = div_half;
               w_n_nxt     = n_cycles;
               w_cpol_nxt  = cpol;
               w_hcnt_nxt  = '0;
               w_tcnt_nxt  = '0;
               w_busy_nxt  = 1'b1;
            end
         end

         S_RUN: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
               w_sclk_nxt  = r_cpol;
               w_busy_nxt  = 1'b0;
            end else if (w_tgl) begin
               w_hcnt_nxt = '0;
               w_tcnt_nxt = r_tcnt + c_TCNT_ONE;
               w_sclk_nxt = ~r_sclk;
               // Odd-numbered toggles (even count so far) leave the idle level
               if (r_tcnt[0] == 1'b0) begin
                  w_lead_nxt = 1'b1;
               end else begin
                  w_trail_nxt = 1'b1;
               end
               if (w_last_tgl) begin
                  w_state_nxt = S_IDLE;
                  w_sclk_nxt  = r_cpol;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
               end
            end else begin
               w_hcnt_nxt = r_hcnt + c_HCNT_ONE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_d     <= '0;
         r_n     <= '0;
         r_cpol  <= 1'b0;
         r_hcnt  <= '0;
         r_tcnt  <= '0;
         r_sclk  <= 1'b0;
         r_lead  <= 1'b0;
         r_trail <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_d     <= w_d_nxt;
         r_n     <= w_n_nxt;
         r_cpol  <= w_cpol_nxt;
         r_hcnt  <= w_hcnt_nxt;
         r_tcnt  <= w_tcnt_nxt;
         r_sclk  <= w_sclk_nxt;
         r_lead  <= w_lead_nxt;
         r_trail <= w_trail_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign sclk      = r_sclk;
   assign lead_stb  = r_lead;
   assign trail_stb = r_trail;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_spi_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_sclk_gen
//  Purpose  : Self-checking bench for spi_sclk_gen against an elapsed-time
//             reference model of the SCLK burst.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_sclk_gen;

   logic       clk_in;
   logic       rst;
   logic       start;
   logic       abort;
   logic [7:0] div_half;
   logic [7:0] n_cycles;
   logic       cpol;
   logic       sclk;
   logic       lead_stb;
   logic       trail_stb;
   logic       busy;
   logic       done;

   logic [4:0] obs;
   assign obs = {sclk, lead_stb, trail_stb, busy, done};

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state: burst origin edge and latched configuration
   int         cyc   = 0;
   bit         m_run = 0;
   int         m_T;
   int         m_D;
   int         m_N;
   bit         m_cpol;
   logic [4:0] e_out;

   spi_sclk_gen #(.DIV_W(8), .CNT_W(8)) dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .div_half  (div_half),
      .n_cycles  (n_cycles),
      .cpol      (cpol),
      .sclk      (sclk),
      .lead_stb  (lead_stb),
      .trail_stb (trail_stb),
      .busy      (busy),
      .done      (done)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Predict outputs after the coming edge from elapsed cycles j = cyc - T:
   // toggle k happens at j = k*(D+1); sclk = cpol ^ (k odd).
   task automatic model_edge();
      int j;
      int k;
      bit s, l, t, b, d;
      cyc++;
      s = 0; l = 0; t = 0; b = 0; d = 0;
      if (rst) begin
         m_run = 0;
      end else if (m_run) begin
         j = cyc - m_T;
         k = j / (m_D + 1);
         if (abort) begin
            m_run = 0;
            s = m_cpol;
         end else begin
            s = m_cpol ^ (k % 2 == 1);
            b = 1;
            if (j % (m_D + 1) == 0) begin
               if (k % 2 == 1) l = 1;
               else            t = 1;
               if (k == 2 * m_N) begin
                  d = 1; b = 0; m_run = 0; s = m_cpol;
               end
            end
         end
      end else begin
         s = cpol;
         if (start && !abort && n_cycles != 0) begin
            m_run = 1; m_T = cyc; m_D = div_half; m_N = n_cycles; m_cpol = cpol;
            b = 1;
         end
      end
      e_out = {s, l, t, b, d};
   endtask

   task automatic step();
      model_edge();
      @(posedge clk_in);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; cpol = 1; start = 0; abort = 0; div_half = 0; n_cycles = 0;
      #1;
      n_checks++;
      if (obs !== 5'b00000) $display("FAIL reset_async: outputs got %b expected 00000", obs);
      else n_pass++;
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks++;
         if (obs !== 5'b00000) $display("FAIL reset_held %0d: outputs got %b expected 00000", i, obs);
         else n_pass++;
      end
      rst = 0;
      step();
      n_checks++;
      if (obs !== e_out || sclk !== 1'b1) $display("FAIL reset_release: outputs got %b expected %b", obs, e_out);
      else n_pass++;
      cpol = 0;
      step();
      n_checks++;
      if (obs !== e_out) $display("FAIL reset_cpol_follow: outputs got %b expected %b", obs, e_out);
      else n_pass++;
   endtask

   task automatic test_basic();
      int leads = 0, trails = 0, busy_cnt = 0, done_idx = -1;
      div_half = 0; n_cycles = 4; cpol = 0; start = 1;
      for (int i = 0; i < 12; i++) begin
         step();
         start = 0;
         n_checks++;
         if (obs !== e_out) $display("FAIL basic cyc %0d: outputs got %b expected %b", i, obs, e_out);
         else n_pass++;
         leads += int'(lead_stb); trails += int'(trail_stb); busy_cnt += int'(busy);
         if (done === 1'b1) done_idx = i;
      end
      n_checks++;
      if (leads != 4 || trails != 4) $display("FAIL basic_strobes: lead/trail got %0d/%0d expected 4/4", leads, trails);
      else n_pass++;
      n_checks++;
      if (busy_cnt != 8 || done_idx != 8) $display("FAIL basic_timing: busy/done_at got %0d/%0d expected 8/8", busy_cnt, done_idx);
      else n_pass++;
   endtask

   task automatic test_cpol1();
      int fall = -1, rise = -1, done_idx = -1;
      bit done_trail = 0;
      logic prev;
      div_half = 2; n_cycles = 1; cpol = 1;
      step();
      n_checks++;
      if (obs !== e_out || sclk !== 1'b1) $display("FAIL cpol1_idle: outputs got %b expected %b", obs, e_out);
      else n_pass++;
      start = 1;
      prev = sclk;
      for (int i = 0; i < 9; i++) begin
         step();
         start = 0;
         n_checks++;
         if (obs !== e_out) $display("FAIL cpol1 cyc %0d: outputs got %b expected %b", i, obs, e_out);
         else n_pass++;
         if (prev === 1'b1 && sclk === 1'b0 && fall < 0) fall = i;
         if (prev === 1'b0 && sclk === 1'b1 && rise < 0) rise = i;
         if (done === 1'b1) begin done_idx = i; done_trail = trail_stb; end
         prev = sclk;
      end
      n_checks++;
      if (fall != 3 || rise != 6 || done_idx != 6 || !done_trail)
         $display("FAIL cpol1_edges: fall/rise/done/trail got %0d/%0d/%0d/%0d expected 3/6/6/1", fall, rise, done_idx, done_trail);
      else n_pass++;
   endtask

   task automatic test_div_change();
      int done_idx = -1;
      div_half = 2; n_cycles = 3; cpol = 0; start = 1;
      for (int i = 0; i < 24; i++) begin
         step();
         start = 0; div_half = 0;
         n_checks++;
         if (obs !== e_out) $display("FAIL divchg cyc %0d: outputs got %b expected %b", i, obs, e_out);
         else n_pass++;
         if (done === 1'b1) done_idx = i;
      end
      n_checks++;
      if (done_idx != 18) $display("FAIL divchg_first_done: got %0d expected 18", done_idx);
      else n_pass++;
      done_idx = -1;
      start = 1;
      for (int i = 0; i < 10; i++) begin
         step();
         start = 0;
         n_checks++;
         if (obs !== e_out) $display("FAIL divchg2 cyc %0d: outputs got %b expected %b", i, obs, e_out);
         else n_pass++;
         if (done === 1'b1) done_idx = i;
      end
      n_checks++;
      if (done_idx != 6) $display("FAIL divchg_second_done: got %0d expected 6", done_idx);
      else n_pass++;
   endtask

   task automatic test_abort();
      int leads = 0;
      div_half = 1; n_cycles = 8; cpol = 1; start = 1;
      for (int i = 0; i < 40 && leads < 3; i++) begin
         step();
         start = 0;
         n_checks++;
         if (obs !== e_out) $display("FAIL abort_run cyc %0d: outputs got %b expected %b", i, obs, e_out);
         else n_pass++;
         leads += int'(lead_stb);
      end
      n_checks++;
      if (leads != 3) $display("FAIL abort_leads: got %0d expected 3", leads);
      else n_pass++;
      abort = 1;
      step();
      abort = 0;
      n_checks++;
      if (obs !== e_out || obs !== 5'b10000) $display("FAIL abort_exit: outputs got %b expected 10000", obs);
      else n_pass++;
      start = 1;
      step();
      start = 0;
      n_checks++;
      if (obs !== e_out || busy !== 1'b1) $display("FAIL abort_restart: outputs got %b expected %b", obs, e_out);
      else n_pass++;
      for (int i = 0; i < 36; i++) begin
         step();
         n_checks++;
         if (obs !== e_out) $display("FAIL abort_rerun cyc %0d: outputs got %b expected %b", i, obs, e_out);
         else n_pass++;
      end
   endtask

   task automatic test_n_zero();
      n_cycles = 0; div_half = 0; cpol = 0; start = 1;
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if (obs !== e_out || obs !== 5'b00000) $display("FAIL nzero cyc %0d: outputs got %b expected 00000", i, obs);
         else n_pass++;
      end
      n_cycles = 3; abort = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (obs !== e_out || busy !== 1'b0) $display("FAIL start_with_abort cyc %0d: outputs got %b expected %b", i, obs, e_out);
         else n_pass++;
      end
      abort = 0; start = 0;
      step();
   endtask

   task automatic test_back_to_back();
      int dones = 0;
      bit prev_done = 0;
      div_half = 0; n_cycles = 2; cpol = 0; start = 1;
      for (int i = 0; i < 20; i++) begin
         step();
         n_checks++;
         if (obs !== e_out) $display("FAIL b2b cyc %0d: outputs got %b expected %b", i, obs, e_out);
         else n_pass++;
         if (prev_done) begin
            n_checks++;
            if (busy !== 1'b1) $display("FAIL b2b_rebusy cyc %0d: busy got %b expected 1", i, busy);
            else n_pass++;
         end
         prev_done = (done === 1'b1);
         dones += int'(done);
      end
      start = 0;
      step();
      n_checks++;
      if (dones != 4) $display("FAIL b2b_done_count: got %0d expected 4", dones);
      else n_pass++;
   endtask

   task automatic test_boundary();
      int done_idx = -1;
      div_half = 8'hFF; n_cycles = 1; cpol = 0; start = 1;
      for (int i = 0; i < 520; i++) begin
         step();
         start = 0;
         n_checks++;
         if (obs !== e_out) $display("FAIL maxdiv cyc %0d: outputs got %b expected %b", i, obs, e_out);
         else n_pass++;
         if (done === 1'b1) done_idx = i;
      end
      n_checks++;
      if (done_idx != 512) $display("FAIL maxdiv_done: got %0d expected 512", done_idx);
      else n_pass++;
      done_idx = -1;
      div_half = 0; n_cycles = 8'hFF; start = 1;
      for (int i = 0; i < 515; i++) begin
         step();
         start = 0;
         n_checks++;
         if (obs !== e_out) $display("FAIL maxn cyc %0d: outputs got %b expected %b", i, obs, e_out);
         else n_pass++;
         if (done === 1'b1) done_idx = i;
      end
      n_checks++;
      if (done_idx != 510) $display("FAIL maxn_done: got %0d expected 510", done_idx);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int done_idx = -1;
      div_half = 1; n_cycles = 4; cpol = 1; start = 1;
      for (int i = 0; i < 6; i++) begin
         step();
         start = 0;
      end
      #2 rst = 1;
      #1;
      m_run = 0;
      n_checks++;
      if (obs !== 5'b00000) $display("FAIL rst_mid_async: outputs got %b expected 00000", obs);
      else n_pass++;
      step();
      n_checks++;
      if (obs !== e_out || obs !== 5'b00000) $display("FAIL rst_mid_held: outputs got %b expected 00000", obs);
      else n_pass++;
      rst = 0;
      step();
      n_checks++;
      if (obs !== e_out || sclk !== 1'b1) $display("FAIL rst_mid_release: outputs got %b expected %b", obs, e_out);
      else n_pass++;
      start = 1;
      for (int i = 0; i < 20; i++) begin
         step();
         start = 0;
         n_checks++;
         if (obs !== e_out) $display("FAIL rst_mid_rerun cyc %0d: outputs got %b expected %b", i, obs, e_out);
         else n_pass++;
         if (done === 1'b1) done_idx = i;
      end
      n_checks++;
      if (done_idx != 16) $display("FAIL rst_mid_rerun_done: got %0d expected 16", done_idx);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         start    = ($urandom_range(0, 2) == 0);
         abort    = ($urandom_range(0, 19) == 0);
         div_half = 8'($urandom_range(0, 3));
         n_cycles = 8'($urandom_range(0, 3));
         cpol     = 1'($urandom_range(0, 1));
         step();
         n_checks++;
         if (obs !== e_out) $display("FAIL random cyc %0d: outputs got %b expected %b", i, obs, e_out);
         else n_pass++;
      end
      start = 0; abort = 0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_cpol1();
      test_div_change();
      test_abort();
      test_n_zero();
      test_back_to_back();
      test_boundary();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
